// File: rtl/receiver_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, oversampling
// factor and the divider rounding helper.
package receiver_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
      ST_RECOVER = 3'd4
   } rx_state_e;

   // Nearest-integer clock divider for a given enable rate.
   function automatic int rate_div(input int clkfreq, input int rate);
      return (clkfreq + rate / 2) / rate;
   endfunction

endpackage

// File: rtl/rate_enb.sv
// Free-running enable generator: enb pulses for one clk cycle every
// round(CLKFREQ/RATE) cycles.
module rate_enb
   import receiver_pkg::*;
#(
   parameter int CLKFREQ = 100_000_000,
   parameter int RATE    = 153_600
) (
   input  logic clk,
   input  logic rst,
   output logic enb
);

   localparam int DIV = rate_div(CLKFREQ, RATE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         enb <= 1'b0;
      end else if (cnt == LAST) begin
         cnt <= '0;
         enb <= 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
         enb <= 1'b0;
      end
   end

endmodule

// File: rtl/receiver.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling, framing-error
// detection and break recovery.
module receiver
   import receiver_pkg::*;
#(
   parameter int BAUD    = 9600,
   parameter int CLKFREQ = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       rdy,
   output logic       ferr,
   output logic [2:0] dbg_state
);

   localparam logic [2:0] IDLE    = ST_IDLE;
   localparam logic [2:0] START   = ST_START;
   localparam logic [2:0] DATA    = ST_DATA;
   localparam logic [2:0] STOP    = ST_STOP;
   localparam logic [2:0] RECOVER = ST_RECOVER;

   localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

   logic [1:0] sync;
   logic       rxs;
   logic [1:0] fill;
   logic       armed;
   logic       tick;
   logic [2:0] state;
   logic [3:0] tick_cnt;
   logic [2:0] bit_cnt;
   logic [7:0] shift;

   assign rxs       = sync[1];
   assign dbg_state = state;

   rate_enb #(
      .CLKFREQ (CLKFREQ),
      .RATE    (BAUD * OVERSAMPLE)
   ) u_rate_enb (
      .clk (clk),
      .rst (rst),
      .enb (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) sync <= 2'b11;
      else     sync <= {sync[0], rxd};
   end

   // The synchronizer resets high, so a line that is already low when rst
   // drops would look like a start edge. Arm start detection only after the
   // flops hold real line samples and the line has been seen idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill  <= 2'd0;
         armed <= 1'b0;
      end else begin
         if (fill != 2'd2) fill <= fill + 2'd1;
         if (fill == 2'd2 && rxs) armed <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tick_cnt <= 4'd0;
         bit_cnt  <= 3'd0;
         shift    <= 8'h00;
         data     <= 8'h00;
         rdy      <= 1'b0;
         ferr     <= 1'b0;
      end else begin
         rdy  <= 1'b0;
         ferr <= 1'b0;
         case (state)
            IDLE: begin
               if (armed && !rxs) begin
                  tick_cnt <= 4'd0;
                  state    <= START;
               end
            end
            START: begin
               if (tick) begin
                  if (tick_cnt == MID_TICK) begin
                     if (!rxs) begin
                        tick_cnt <= 4'd0;
                        bit_cnt  <= 3'd0;
                        state    <= DATA;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  tick_cnt <= tick_cnt + 4'd1;
                  if (tick_cnt == LAST_TICK) begin
                     shift   <= {rxs, shift[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) state <= STOP;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  tick_cnt <= tick_cnt + 4'd1;
                  if (tick_cnt == LAST_TICK) begin
                     if (rxs) begin
                        data  <= shift;
                        rdy   <= 1'b1;
                        state <= IDLE;
                     end else begin
                        ferr  <= 1'b1;
                        state <= RECOVER;
                     end
                  end
               end
            end
            RECOVER: begin
               if (rxs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: table-driven frames plus hand-written
// glitch, break, back-to-back and mid-frame reset sequences.
module tb_receiver;

   localparam int BAUD    = 10_000;
   localparam int CLKFREQ = 1_600_000;
   localparam int BIT     = 160;          // clk cycles per bit at nominal baud
   localparam int BIT_FAST = 155;         // BAUD * 1.03
   localparam int BIT_SLOW = 165;         // BAUD * 0.97

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic [7:0] data;
   logic       rdy;
   logic       ferr;
   logic [2:0] dbg_state;

   receiver #(
      .BAUD    (BAUD),
      .CLKFREQ (CLKFREQ)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .data      (data),
      .rdy       (rdy),
      .ferr      (ferr),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: cycle budget exhausted, got %0d cycles required < 90000", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         rdy_cnt  = 0;
   int         ferr_cnt = 0;
   int         exp_rdy  = 0;
   int         exp_ferr = 0;
   int         last_rdy_cyc = 0;
   logic [7:0] last_good = 8'h00;
   logic       prev_rdy = 1'b0;
   logic       prev_ferr = 1'b0;
   logic [7:0] exp_byte;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rdy || ferr) begin
         check("rdy_ferr_exclusive", 32'(rdy & ferr), 32'd0);
         check("pulse_one_cycle", 32'((rdy & prev_rdy) | (ferr & prev_ferr)), 32'd0);
      end
      if (rdy) begin
         rdy_cnt++;
         last_rdy_cyc = cyc;
         check("rdy_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            exp_byte = exp_q.pop_front();
            check("rx_data", 32'(data), 32'(exp_byte));
         end
      end
      if (ferr) ferr_cnt++;
      prev_rdy  = rdy;
      prev_ferr = ferr;
   end

   // ---------------- driver tasks ----------------
   task automatic send_frame(input logic [7:0] b, input int bc, input logic stop);
      rxd = 1'b0;
      repeat (bc) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (bc) @(negedge clk);
      end
      rxd = stop;
      repeat (bc) @(negedge clk);
   endtask

   task automatic send_good(input logic [7:0] b, input int bc);
      exp_q.push_back(b);
      exp_rdy++;
      last_good = b;
      send_frame(b, bc, 1'b1);
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic checkpoint(input string name);
      check({name, "_rdy_count"}, 32'(rdy_cnt), 32'(exp_rdy));
      check({name, "_ferr_count"}, 32'(ferr_cnt), 32'(exp_ferr));
      check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
      check({name, "_data_held"}, 32'(data), 32'(last_good));
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [7:0] data;
      int         bc;
      logic       stop;
      int         gap;
   } vec_t;

   vec_t vecs[8];
   int   t0;

   initial begin
      vecs[0] = '{8'h3C, BIT,      1'b1, 200};   // loopback, nominal rate
      vecs[1] = '{8'h3C, BIT_FAST, 1'b1, 200};   // loopback, +3 %
      vecs[2] = '{8'hA5, BIT_SLOW, 1'b1, 200};   // -3 %
      vecs[3] = '{8'h00, BIT,      1'b1, 200};
      vecs[4] = '{8'hFF, BIT_FAST, 1'b1, 200};
      vecs[5] = '{8'h96, BIT,      1'b0, 300};   // stop bit low
      vecs[6] = '{8'h01, BIT,      1'b1, 200};
      vecs[7] = '{8'h80, BIT_SLOW, 1'b1, 200};

      rst = 1'b1;
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_data", 32'(data), 32'h00);
      check("reset_rdy", 32'(rdy), 32'd0);
      check("reset_ferr", 32'(ferr), 32'd0);
      check("reset_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      idle(20);

      // single 0x55 with latency to rdy (~9.5 bit times from start edge)
      t0 = cyc;
      send_good(8'h55, BIT);
      idle(40);
      checkpoint("f55");
      check("f55_latency_in_window", 32'((last_rdy_cyc - t0) inside {[1505:1535]}), 32'd1);

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].stop) begin
            send_good(vecs[i].data, vecs[i].bc);
         end else begin
            exp_ferr++;
            send_frame(vecs[i].data, vecs[i].bc, 1'b0);
         end
         idle(vecs[i].gap);
         checkpoint($sformatf("vec%0d", i));
      end

      // short low glitch on idle line is a false start
      rxd = 1'b0;
      repeat (30) @(negedge clk);
      idle(400);
      checkpoint("glitch");
      check("glitch_state_idle", 32'(dbg_state), 32'd0);

      // good frame, bad stop bit, then a long break
      send_good(8'h12, BIT);
      idle(40);
      checkpoint("f12");
      exp_ferr++;
      send_frame(8'hA3, BIT, 1'b0);
      repeat (48 * BIT) @(negedge clk);
      check("break_state_recover", 32'(dbg_state), 32'd4);
      idle(200);
      checkpoint("break");
      send_good(8'h0F, BIT);
      idle(40);
      checkpoint("f0f");

      // back-to-back frames, no idle bits
      send_good(8'h00, BIT);
      send_good(8'hFF, BIT);
      send_good(8'h81, BIT);
      idle(40);
      checkpoint("b2b");

      // one-cycle reset in the middle of bit 4 of 0xC3
      fork
         send_frame(8'hC3, BIT, 1'b1);
         begin
            repeat (5 * BIT + 80) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      join
      last_good = 8'h00;
      idle(200);
      checkpoint("rst_mid");
      send_good(8'h7E, BIT);
      idle(40);
      checkpoint("f7e");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter BAUD, default 9600: serial bit rate in bits/s.
REQ-002 Parameter CLKFREQ, default 100_000_000: clk frequency in Hz.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 rxd  input  1  asynchronous serial line; idles high; 8N1 framing, LSB first.
REQ-006 data  output  8  last correctly framed byte; held until the next good byte.
REQ-007 rdy  output  1  one-cycle pulse: new byte valid on data.
REQ-008 ferr  output  1  one-cycle pulse: stop bit sampled low (framing error).

Function
REQ-009 rxd SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value (rxs) only.
REQ-010 A free-running tick enable SHALL pulse once every DIV = round(CLKFREQ/(BAUD*16)) clk cycles (651 at defaults), giving 16 ticks per bit.
REQ-011 FSM states: IDLE, START, DATA, STOP, RECOVER; tick counter 4 bits; bit counter 3 bits.
REQ-012 IDLE: on rxs==0, clear tick counter, go to START.
REQ-013 START: on the 8th tick (bit mid), rxs==0 -> clear counters, go to DATA; rxs==1 -> false start, go to IDLE, no output activity.
REQ-014 DATA: every 16th tick sample rxs, shift into an 8-bit register LSB first; after the 8th sample go to STOP.
REQ-015 STOP: on the 16th tick, rxs==1 -> load data from shift register, pulse rdy, go to IDLE; rxs==0 -> pulse ferr, data unchanged, go to RECOVER.
REQ-016 RECOVER: stay until rxs==1, then go to IDLE; a held-low line (break) SHALL produce exactly one ferr and no rdy.
REQ-017 rdy/ferr SHALL assert in the clk cycle immediately after the stop-bit sample tick and last exactly one cycle; never both high.
REQ-018 A start edge arriving in the cycle rdy is asserted SHALL be accepted; back-to-back frames with no idle gap SHALL be received without loss.
REQ-019 Tolerance: frames at BAUD +/-3% SHALL be received correctly.

Reset
REQ-020 On rst: state IDLE, all counters 0, shift register 0, data=8'h00, rdy=0, ferr=0, synchronizer flops=1.
REQ-021 rst asserted mid-frame SHALL abandon the frame with no rdy/ferr pulse; reception resumes on the next falling edge after rst deasserts.
REQ-022 The tick divider SHALL reset to 0 with rst.

Structure
REQ-023 A shared package SHALL hold the FSM state enum type and constant OVERSAMPLE=16.
REQ-024 The tick generator SHALL be a sub-module rate_enb (parameters CLKFREQ, RATE; ports clk, rst, enb); receiver instantiates it with RATE=BAUD*16.
REQ-025 The synchronizer, FSM, counters and shift register reside in receiver.

Verification
REQ-026 Send 0x55 at 9600 baud -> data==0x55, exactly one rdy pulse ~1 cycle after stop-bit mid (~0.99 ms after start edge), ferr never high.
REQ-027 3 us low glitch on idle rxd -> FSM returns to IDLE, no rdy, no ferr, data unchanged.
REQ-028 After good 0x12, send 0xA3 with stop bit driven low -> one ferr pulse, no rdy, data stays 0x12; then hold rxd low 5 ms -> no further pulses; release and send 0x0F -> data==0x0F.
REQ-029 Back-to-back 0x00, 0xFF, 0x81 with zero idle bits -> three rdy pulses, data sequence 0x00, 0xFF, 0x81.
REQ-030 Assert rst 1 cycle during bit 4 of a 0xC3 frame -> no rdy/ferr, data==0x00; the following 0x7E frame -> data==0x7E.
REQ-031 Loopback with transmitter (data=0x3C, send pulse, same BAUD) and at BAUD*1.03 -> receiver data==0x3C, one rdy pulse each.
